// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: default widths,
// the output-stage state encoding and the requester index constants.
package regfile_wport_arbiter_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int REG_BITS_DEF = 4;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// Bundle of the two requester handshakes and the register-file write port.
// Handshake: a requester write is transferred in a cycle where its valid and its ready are both high.
interface regfile_wport_arbiter_if
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int REG_BITS = REG_BITS_DEF
) ();

    logic                       req0_valid;
    logic [REG_BITS-1:0]        req0_reg;
    logic [DATA_W-1:0]          req0_data;
    logic                       req0_ready;
    logic                       req1_valid;
    logic [REG_BITS-1:0]        req1_reg;
    logic [DATA_W-1:0]          req1_data;
    logic                       req1_ready;
    logic                       wr_stall;
    logic                       wr_en;
    logic [REG_BITS-1:0]        wr_reg;
    logic [(1<<REG_BITS)-1:0]   wr_wordline;
    logic [DATA_W-1:0]          wr_data;
    logic                       busy;

    modport master (
        output req0_valid, req0_reg, req0_data,
        output req1_valid, req1_reg, req1_data,
        output wr_stall,
        input  req0_ready, req1_ready,
        input  wr_en, wr_reg, wr_wordline, wr_data, busy
    );

    modport slave (
        input  req0_valid, req0_reg, req0_data,
        input  req1_valid, req1_reg, req1_data,
        input  wr_stall,
        output req0_ready, req1_ready,
        output wr_en, wr_reg, wr_wordline, wr_data, busy
    );

endinterface

// File: rtl/regfile_wr_decoder.sv
// Register id to one-hot wordline decoder; the wordline is all-zero while en is low.
module regfile_wr_decoder #(
    parameter int REG_BITS = 4
) (
    input  logic                     en,
    input  logic [REG_BITS-1:0]      reg_id,
    output logic [(1<<REG_BITS)-1:0] wordline
);

    always_comb begin
        wordline = '0;
        if (en) begin
            wordline[reg_id] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Round-robin arbiter sharing one register-file write port between two writeback
// requesters, with a single registered output stage that holds under wr_stall.
module regfile_wport_arbiter
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int REG_BITS = REG_BITS_DEF,
    parameter bit DROP_R0  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wport_arbiter_if.slave bus,
    output state_t                state
);

    state_t                   state_q;
    state_t                   state_d;
    logic                     full_q;
    logic [REG_BITS-1:0]      reg_q;
    logic [DATA_W-1:0]        data_q;
    logic                     rr_last;

    logic                     accept;
    logic                     grant;
    logic                     gnt_idx;
    logic [REG_BITS-1:0]      gnt_reg;
    logic [DATA_W-1:0]        gnt_data;
    logic                     drop;
    logic                     stage_frozen;
    logic [(1<<REG_BITS)-1:0] wordline;

    assign stage_frozen = full_q && bus.wr_stall;

    always_comb begin
        accept   = 1'b0;
        grant    = 1'b0;
        gnt_idx  = REQ0;
        gnt_reg  = bus.req0_reg;
        gnt_data = bus.req0_data;
        drop     = 1'b0;
        state_d  = IDLE;

        // The stage can take a new write whenever it is empty or draining this cycle.
        accept = !rst && !stage_frozen;
        grant  = accept && (bus.req0_valid || bus.req1_valid);

        if (bus.req0_valid && bus.req1_valid) begin
            gnt_idx = ~rr_last;
        end else begin
            gnt_idx = bus.req1_valid;
        end

        if (gnt_idx == REQ1) begin
            gnt_reg  = bus.req1_reg;
            gnt_data = bus.req1_data;
        end

        drop = DROP_R0 && (gnt_reg == '0);

        if (stage_frozen) begin
            state_d = HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            full_q  <= 1'b0;
            reg_q   <= '0;
            data_q  <= '0;
            rr_last <= REQ1;
        end else begin
            state_q <= state_d;
            if (grant) begin
                rr_last <= gnt_idx;
            end
            if (!stage_frozen) begin
                full_q <= grant && !drop;
                if (grant && !drop) begin
                    reg_q  <= gnt_reg;
                    data_q <= gnt_data;
                end
            end
        end
    end

    regfile_wr_decoder #(
        .REG_BITS (REG_BITS)
    ) u_decoder (
        .en       (full_q),
        .reg_id   (reg_q),
        .wordline (wordline)
    );

    assign bus.req0_ready  = grant && (gnt_idx == REQ0);
    assign bus.req1_ready  = grant && (gnt_idx == REQ1);
    assign bus.wr_en       = full_q;
    assign bus.wr_reg      = reg_q;
    assign bus.wr_data     = data_q;
    assign bus.wr_wordline = wordline;
    assign bus.busy        = (state_q == HOLD);
    assign state           = state_q;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Bench for regfile_wport_arbiter: directed cycle table followed by randomized
// traffic checked against a queue-based model of the write port and register file.
module tb_regfile_wport_arbiter;
    import regfile_wport_arbiter_pkg::*;

    localparam int DW = 16;
    localparam int RB = 4;
    localparam int NV = 27;
    localparam int N_RAND = 500;

    logic   clk;
    logic   rst;
    state_t dut_state;

    regfile_wport_arbiter_if #(.DATA_W(DW), .REG_BITS(RB)) bus ();

    regfile_wport_arbiter #(
        .DATA_W   (DW),
        .REG_BITS (RB),
        .DROP_R0  (1'b1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .state (dut_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        v0;
        logic [3:0]  r0;
        logic [15:0] d0;
        logic        v1;
        logic [3:0]  r1;
        logic [15:0] d1;
        logic        stall;
        logic        e_rdy0;
        logic        e_rdy1;
        logic        e_en;
        logic [3:0]  e_reg;
        logic [15:0] e_wl;
        logic [15:0] e_data;
        logic        e_busy;
    } vec_t;

    vec_t vecs[NV];

    function automatic vec_t mk(input int rs, input int v0, input int r0, input int d0,
                                input int v1, input int r1, input int d1, input int st,
                                input int e0, input int e1, input int en, input int er,
                                input int ewl, input int ed, input int eb);
        vec_t v;
        v.rst = 1'(rs);  v.v0 = 1'(v0); v.r0 = 4'(r0); v.d0 = 16'(d0);
        v.v1 = 1'(v1);   v.r1 = 4'(r1); v.d1 = 16'(d1); v.stall = 1'(st);
        v.e_rdy0 = 1'(e0); v.e_rdy1 = 1'(e1); v.e_en = 1'(en); v.e_reg = 4'(er);
        v.e_wl = 16'(ewl); v.e_data = 16'(ed); v.e_busy = 1'(eb);
        return v;
    endfunction

    // Register-file images: one built from the spec model, one from observed commits.
    logic [DW-1:0] rf_exp[16];
    logic [DW-1:0] rf_got[16];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf_got[i] <= '0;
        end else if (bus.wr_en && !bus.wr_stall) begin
            rf_got[bus.wr_reg] <= bus.wr_data;
        end
    end

    typedef struct packed {
        logic [RB-1:0] r;
        logic [DW-1:0] d;
    } wr_t;

    wr_t         pend_q[$];
    logic        pref;
    logic        took0, took1;
    logic        can_take, e0, e1, win;
    logic [15:0] one16;
    wr_t         head;

    task automatic drive_idle();
        bus.req0_valid = 1'b0; bus.req0_reg = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_reg = '0; bus.req1_data = '0;
        bus.wr_stall   = 1'b0;
    endtask

    initial begin
        one16 = 16'h0001;
        rst = 1'b1;
        drive_idle();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;

        //        rst v0 r0 d0      v1 r1 d1      st  rdy0 rdy1 en reg wl       data    busy
        vecs[0]  = mk(1, 1, 5, 'h1111, 1, 9, 'h2222, 0,  0, 0, 0, 0, 'h0000, 'h0000, 0);
        vecs[1]  = mk(0, 1, 5, 'hBEEF, 0, 0, 0,      0,  1, 0, 0, 0, 'h0000, 'h0000, 0);
        vecs[2]  = mk(0, 0, 0, 0,      0, 0, 0,      0,  0, 0, 1, 5, 'h0020, 'hBEEF, 0);
        vecs[3]  = mk(0, 1, 3, 'h0003, 1, 9, 'h0009, 0,  0, 1, 0, 5, 'h0000, 'hBEEF, 0);
        vecs[4]  = mk(0, 1, 3, 'h0003, 1, 9, 'h0009, 0,  1, 0, 1, 9, 'h0200, 'h0009, 0);
        vecs[5]  = mk(0, 1, 3, 'h0003, 1, 9, 'h0009, 0,  0, 1, 1, 3, 'h0008, 'h0003, 0);
        vecs[6]  = mk(0, 1, 3, 'h0003, 1, 9, 'h0009, 0,  1, 0, 1, 9, 'h0200, 'h0009, 0);
        vecs[7]  = mk(0, 0, 0, 0,      0, 0, 0,      0,  0, 0, 1, 3, 'h0008, 'h0003, 0);
        vecs[8]  = mk(0, 1, 7, 'h1234, 0, 0, 0,      0,  1, 0, 0, 3, 'h0000, 'h0003, 0);
        vecs[9]  = mk(0, 0, 0, 0,      1, 2, 'h2222, 1,  0, 0, 1, 7, 'h0080, 'h1234, 0);
        vecs[10] = mk(0, 0, 0, 0,      1, 2, 'h2222, 1,  0, 0, 1, 7, 'h0080, 'h1234, 1);
        vecs[11] = mk(0, 0, 0, 0,      1, 2, 'h2222, 1,  0, 0, 1, 7, 'h0080, 'h1234, 1);
        vecs[12] = mk(0, 0, 0, 0,      1, 2, 'h2222, 0,  0, 1, 1, 7, 'h0080, 'h1234, 1);
        vecs[13] = mk(0, 0, 0, 0,      0, 0, 0,      0,  0, 0, 1, 2, 'h0004, 'h2222, 0);
        vecs[14] = mk(0, 0, 0, 0,      1, 0, 'hFFFF, 0,  0, 1, 0, 2, 'h0000, 'h2222, 0);
        vecs[15] = mk(0, 1, 1, 'h0101, 1, 4, 'h0404, 0,  1, 0, 0, 2, 'h0000, 'h2222, 0);
        vecs[16] = mk(0, 0, 0, 0,      0, 0, 0,      0,  0, 0, 1, 1, 'h0002, 'h0101, 0);
        vecs[17] = mk(0, 0, 0, 0,      1, 6, 'h0606, 0,  0, 1, 0, 1, 'h0000, 'h0101, 0);
        vecs[18] = mk(0, 0, 0, 0,      0, 0, 0,      1,  0, 0, 1, 6, 'h0040, 'h0606, 0);
        vecs[19] = mk(0, 0, 0, 0,      0, 0, 0,      1,  0, 0, 1, 6, 'h0040, 'h0606, 1);
        vecs[20] = mk(1, 1, 5, 'h5555, 0, 0, 0,      1,  0, 0, 1, 6, 'h0040, 'h0606, 1);
        vecs[21] = mk(0, 0, 0, 0,      0, 0, 0,      0,  0, 0, 0, 0, 'h0000, 'h0000, 0);
        vecs[22] = mk(0, 1, 8, 'h0808, 0, 0, 0,      1,  1, 0, 0, 0, 'h0000, 'h0000, 0);
        vecs[23] = mk(0, 0, 0, 0,      0, 0, 0,      1,  0, 0, 1, 8, 'h0100, 'h0808, 0);
        vecs[24] = mk(0, 0, 0, 0,      0, 0, 0,      1,  0, 0, 1, 8, 'h0100, 'h0808, 1);
        vecs[25] = mk(0, 0, 0, 0,      0, 0, 0,      0,  0, 0, 1, 8, 'h0100, 'h0808, 1);
        vecs[26] = mk(0, 0, 0, 0,      0, 0, 0,      0,  0, 0, 0, 8, 'h0000, 'h0808, 0);

        // First reset edge is unchecked; vecs[0] holds reset for the second cycle.
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            rst            = vecs[i].rst;
            bus.req0_valid = vecs[i].v0;
            bus.req0_reg   = vecs[i].r0;
            bus.req0_data  = vecs[i].d0;
            bus.req1_valid = vecs[i].v1;
            bus.req1_reg   = vecs[i].r1;
            bus.req1_data  = vecs[i].d1;
            bus.wr_stall   = vecs[i].stall;
            #2;
            chk($sformatf("vec%0d.req0_ready", i), 32'(bus.req0_ready), 32'(vecs[i].e_rdy0));
            chk($sformatf("vec%0d.req1_ready", i), 32'(bus.req1_ready), 32'(vecs[i].e_rdy1));
            chk($sformatf("vec%0d.wr_en", i), 32'(bus.wr_en), 32'(vecs[i].e_en));
            chk($sformatf("vec%0d.wr_reg", i), 32'(bus.wr_reg), 32'(vecs[i].e_reg));
            chk($sformatf("vec%0d.wr_wordline", i), 32'(bus.wr_wordline), 32'(vecs[i].e_wl));
            chk($sformatf("vec%0d.wr_data", i), 32'(bus.wr_data), 32'(vecs[i].e_data));
            chk($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
            @(posedge clk); #1;
        end

        // Randomized phase starts from a fresh reset: req0 preferred, stage empty.
        rst = 1'b1;
        drive_idle();
        for (int i = 0; i < 16; i++) rf_exp[i] = '0;
        @(posedge clk); #1;
        rst   = 1'b0;
        pref  = 1'b0;
        took0 = 1'b1;
        took1 = 1'b1;
        pend_q.delete();

        for (int c = 0; c < N_RAND; c++) begin
            if (took0 || !bus.req0_valid) begin
                bus.req0_valid = ($urandom_range(0, 3) != 0);
                bus.req0_reg   = 4'($urandom_range(0, 15));
                bus.req0_data  = 16'($urandom);
            end
            if (took1 || !bus.req1_valid) begin
                bus.req1_valid = ($urandom_range(0, 3) != 0);
                bus.req1_reg   = 4'($urandom_range(0, 15));
                bus.req1_data  = 16'($urandom);
            end
            bus.wr_stall = ($urandom_range(0, 3) == 0);
            #2;

            can_take = (pend_q.size() == 0) || !bus.wr_stall;
            e0  = 1'b0;
            e1  = 1'b0;
            win = 1'b0;
            if (can_take && (bus.req0_valid || bus.req1_valid)) begin
                win = (bus.req0_valid && bus.req1_valid) ? pref : bus.req1_valid;
                e0  = (win == 1'b0);
                e1  = (win == 1'b1);
            end

            chk("rand.req0_ready", 32'(bus.req0_ready), 32'(e0));
            chk("rand.req1_ready", 32'(bus.req1_ready), 32'(e1));
            chk("rand.ready_overlap", 32'(bus.req0_ready && bus.req1_ready), 32'(0));
            chk("rand.wr_en", 32'(bus.wr_en), 32'(pend_q.size() != 0));
            if (pend_q.size() != 0) begin
                head = pend_q[0];
                chk("rand.wr_reg", 32'(bus.wr_reg), 32'(head.r));
                chk("rand.wr_data", 32'(bus.wr_data), 32'(head.d));
                chk("rand.wr_wordline", 32'(bus.wr_wordline), 32'(one16 << head.r));
            end else begin
                chk("rand.wr_wordline", 32'(bus.wr_wordline), 32'(0));
            end

            if (pend_q.size() != 0 && !bus.wr_stall) begin
                head = pend_q.pop_front();
                rf_exp[head.r] = head.d;
            end
            if (e0 || e1) begin
                pref = ~win;
                if (e0 && bus.req0_reg != 0) pend_q.push_back({bus.req0_reg, bus.req0_data});
                if (e1 && bus.req1_reg != 0) pend_q.push_back({bus.req1_reg, bus.req1_data});
            end
            took0 = e0;
            took1 = e1;

            @(posedge clk); #1;
        end

        drive_idle();
        for (int c = 0; c < 3; c++) begin
            if (pend_q.size() != 0) begin
                head = pend_q.pop_front();
                rf_exp[head.r] = head.d;
            end
            @(posedge clk); #1;
        end

        for (int i = 0; i < 16; i++) begin
            chk($sformatf("regfile[%0d]", i), 32'(rf_got[i]), 32'(rf_exp[i]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
